piso_tx_arbiter: RTL and testbench
==================================

# piso_tx_arbiter

Round-robin transmit controller that shares one parallel-in/serial-out shifter among R requesters. On each grant it captures the winner's N-bit word, acknowledges it, shifts it out MSB-first on a single serial line with a valid strobe, and signals completion. It sits between word-producing blocks and a one-wire serial link.

## Interface
- N, 4, word width in bits (N ≥ 2)
- R, 2, number of requesters (R ≥ 1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  R  per-requester request level; sampled only in IDLE
- data  input  R*N  packed words; requester i occupies data[i*N +: N]
- ack  output  R  one-hot, one-cycle pulse: winner's word captured
- gnt  output  R  one-hot, held from capture until completion
- so  output  1  serial data, registered, MSB first
- so_valid  output  1  so carries a valid bit
- sof  output  1  high with the first bit of each word only
- done  output  1  one-cycle pulse after the last bit
- busy  output  1  high while a word is owned (SHIFT or DONE)

## Operation
- Internal state: N-bit shift register, bit counter (width clog2(N+1)), round-robin pointer ptr (clog2(R) bits, min 1), FSM {IDLE, SHIFT, DONE}.
- Arbitration: the winner is the first asserted req[i] searching i = ptr, ptr+1, … modulo R. Only one grant at a time.
- IDLE: if req ≠ 0, then on the edge: shreg ← winner's word, gnt ← onehot(winner), ack ← onehot(winner), cnt ← 0, busy ← 1, state → SHIFT. If req = 0: stay, all strobes 0.
- SHIFT: on each edge: so ← shreg[N-1], shreg ← shreg << 1, so_valid ← 1, sof ← (cnt == 0), cnt ← cnt+1, ack ← 0. On the edge where cnt reaches N, state → DONE.
- DONE: on the edge: so ← 0, so_valid ← 0, sof ← 0, gnt ← 0, busy ← 0, done ← 1, ptr ← (winner+1) mod R, state → IDLE.
- IDLE with done high clears done on the next edge; a new grant may happen on that same edge.
- req changes, or changes to data, after capture have no effect on the word in flight; gnt stays asserted until the DONE edge.
- The word is captured only once, at grant. Requesters keep req asserted to queue another word, and may change data after ack.
- R = 1: ptr is constant 0, and the block degenerates to a single-source serializer.

## Timing
- Reset (rst = 0, asynchronous, any state): so, so_valid, sof, done, busy = 0; ack, gnt = 0; ptr = 0; shreg, cnt = 0; state = IDLE. Any transfer in progress is abandoned with no done pulse. The first grant after release happens at the first edge with rst = 1 and req ≠ 0.
- With the grant edge as E0:
  - ack, gnt and busy are high after E0.
  - Bit k (k = 0 is the MSB) is on so after E(k+1), for k = 0…N-1; sof is high after E1 only.
  - so_valid is high after E1 through E(N+1), exactly N cycles.
  - done is high and busy/gnt are low after E(N+1).
  - The earliest next grant is at E(N+2). Period under continuous requests is N+2 cycles; latency from grant to first bit is 1 cycle.
- ack is high for exactly one cycle per word, and done for exactly one cycle per word. They never coincide, since N ≥ 2.
- Simultaneous requests are resolved purely by ptr. A requester that was just served has the lowest priority for the next grant.

## Test plan
- Reset: hold rst = 0 with req = 2'b11 → all outputs 0 and no grant. Assert rst = 0 mid-SHIFT → so, so_valid and busy drop immediately, with no done.
- Single word, N = 4: req = 2'b01, data[3:0] = 4'b1100 at E0 → ack = 2'b01 for one cycle; so = 1, 1, 0, 0 after E1–E4 with sof after E1 only; done after E5; busy low after E5.
- Fairness: req = 2'b11 held, data0 = 4'b1010, data1 = 4'b0110 → grants alternate 01, 10, 01, 10; serial stream 1010 0110 1010 …; new grants every 6 cycles.
- Mid-transfer changes: grant req0 with data0 = 4'b1001, then drop req0 and change data0 to 4'b0000 after E1 → stream is still 1,0,0,1; done is still pulsed; gnt is held until E5.
- Pointer retention: serve req1 alone, then assert req = 2'b11 → requester 0 is granted first (ptr = 0 after serving 1).
- Back-to-back single requester: req = 2'b01 held, words 4'b1111 then 4'b0001 → so_valid low for exactly 2 cycles between words; second ack at E6.

Source files
------------

// File: rtl/piso_tx_arbiter.sv
// Round-robin transmit controller: grants one of R requesters, captures its N-bit
// word and shifts it out MSB-first on a single serial line with valid/sof/done strobes.
module piso_tx_arbiter #(
    parameter int N = 4,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] data,
    output logic [R-1:0]   ack,
    output logic [R-1:0]   gnt,
    output logic           so,
    output logic           so_valid,
    output logic           sof,
    output logic           done,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic [N-1:0]    win_word;
    logic [R-1:0]    win_oh;
    logic [PW-1:0]   ptr_next;

    function automatic logic [R-1:0] onehot(input logic [PW-1:0] idx);
        logic [R-1:0] o;
        o = '0;
        o[idx] = 1'b1;
        return o;
    endfunction

    // Search starts at ptr and wraps, so the last-served requester is checked last.
    always_comb begin
        found    = 1'b0;
        win      = ptr;
        cand     = ptr;
        win_word = '0;
        for (int k = 0; k < R; k++) begin
            cand = PW'((int'(ptr) + k) % R);
            if (!found && req[cand]) begin
                found    = 1'b1;
                win      = cand;
                win_word = data[cand*N +: N];
            end
        end
        win_oh   = onehot(win);
        ptr_next = PW'((int'(owner) + 1) % R);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            ptr      <= '0;
            owner    <= '0;
            ack      <= '0;
            gnt      <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            sof      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    ack      <= '0;
                    so       <= 1'b0;
                    so_valid <= 1'b0;
                    sof      <= 1'b0;
                    if (found) begin
                        shreg <= win_word;
                        gnt   <= win_oh;
                        ack   <= win_oh;
                        owner <= win;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    so       <= shreg[N-1];
                    shreg    <= {shreg[N-2:0], 1'b0};
                    so_valid <= 1'b1;
                    sof      <= (cnt == '0);
                    cnt      <= cnt + CW'(1);
                    ack      <= '0;
                    if (cnt == CW'(N - 1))
                        state <= DONE;
                end
                DONE: begin
                    so       <= 1'b0;
                    so_valid <= 1'b0;
                    sof      <= 1'b0;
                    gnt      <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    ptr      <= ptr_next;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter (N=4, R=2) with a serial-bit scoreboard queue.
module tb_piso_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] data;
    logic [1:0] ack;
    logic [1:0] gnt;
    logic       so;
    logic       so_valid;
    logic       sof;
    logic       done;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic exp_q[$];

    piso_tx_arbiter #(.N(4), .R(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .gnt      (gnt),
        .so       (so),
        .so_valid (so_valid),
        .sof      (sof),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ack"},      8'(ack),      8'h0);
        check({tag, ".gnt"},      8'(gnt),      8'h0);
        check({tag, ".so"},       8'(so),       8'h0);
        check({tag, ".so_valid"}, 8'(so_valid), 8'h0);
        check({tag, ".sof"},      8'(sof),      8'h0);
        check({tag, ".busy"},     8'(busy),     8'h0);
    endtask

    // Next rising edge must be the grant edge E0 for requester eg with word w.
    task automatic xfer(input string tag, input logic [1:0] eg, input logic [3:0] w,
                        input bit chg, input logic [1:0] nreq, input logic [7:0] ndata);
        logic b;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[3-k]);
        tick();
        check({tag, ".E0.ack"},  8'(ack),      8'(eg));
        check({tag, ".E0.gnt"},  8'(gnt),      8'(eg));
        check({tag, ".E0.busy"}, 8'(busy),     8'h1);
        check({tag, ".E0.vld"},  8'(so_valid), 8'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            b = exp_q.pop_front();
            check($sformatf("%s.E%0d.so", tag, k),   8'(so),       8'(b));
            check($sformatf("%s.E%0d.vld", tag, k),  8'(so_valid), 8'h1);
            check($sformatf("%s.E%0d.sof", tag, k),  8'(sof),      (k == 1) ? 8'h1 : 8'h0);
            check($sformatf("%s.E%0d.ack", tag, k),  8'(ack),      8'h0);
            check($sformatf("%s.E%0d.gnt", tag, k),  8'(gnt),      8'(eg));
            check($sformatf("%s.E%0d.done", tag, k), 8'(done),     8'h0);
            if (k == 1 && chg) begin
                req  = nreq;
                data = ndata;
            end
        end
        tick();
        check({tag, ".E5.done"}, 8'(done),     8'h1);
        check({tag, ".E5.busy"}, 8'(busy),     8'h0);
        check({tag, ".E5.gnt"},  8'(gnt),      8'h0);
        check({tag, ".E5.vld"},  8'(so_valid), 8'h0);
        check({tag, ".E5.so"},   8'(so),       8'h0);
    endtask

    initial begin
        rst  = 1'b0;
        req  = 2'b11;
        data = {4'b0110, 4'b1010};

        // Reset held with both requests pending: nothing may be granted.
        repeat (3) tick();
        check_idle("rst_hold");
        check("rst_hold.done", 8'(done), 8'h0);

        // Single word from requester 0.
        req  = 2'b01;
        data = {4'b0000, 4'b1100};
        rst  = 1'b1;
        xfer("single", 2'b01, 4'b1100, 1'b0, 2'b00, 8'h00);
        req = 2'b00;
        tick();
        check("single.done_1cyc", 8'(done), 8'h0);
        check_idle("single.after");

        // Pointer retention: serve requester 1, then requester 0 wins a tie.
        req  = 2'b10;
        data = {4'b0110, 4'b1010};
        xfer("ptr_r1", 2'b10, 4'b0110, 1'b0, 2'b00, 8'h00);

        // Fairness under continuous requests, one grant every 6 cycles.
        req = 2'b11;
        xfer("fair0", 2'b01, 4'b1010, 1'b0, 2'b00, 8'h00);
        xfer("fair1", 2'b10, 4'b0110, 1'b0, 2'b00, 8'h00);
        xfer("fair2", 2'b01, 4'b1010, 1'b0, 2'b00, 8'h00);
        xfer("fair3", 2'b10, 4'b0110, 1'b0, 2'b00, 8'h00);
        req = 2'b00;
        tick();
        check_idle("fair.after");

        // req and data change after capture must not disturb the word in flight.
        req  = 2'b01;
        data = {4'b0000, 4'b1001};
        xfer("midchg", 2'b01, 4'b1001, 1'b1, 2'b00, 8'h00);
        tick();
        check_idle("midchg.after");

        // Back-to-back from one requester; data updated after ack.
        req  = 2'b01;
        data = {4'b0000, 4'b1111};
        xfer("b2b0", 2'b01, 4'b1111, 1'b1, 2'b01, {4'b0000, 4'b0001});
        xfer("b2b1", 2'b01, 4'b0001, 1'b0, 2'b00, 8'h00);
        req = 2'b00;
        tick();
        check_idle("b2b.after");

        // Asynchronous reset in the middle of SHIFT abandons the word without done.
        req  = 2'b01;
        data = {4'b0000, 4'b1111};
        tick();
        check("abort.E0.ack", 8'(ack), 8'h1);
        tick();
        tick();
        check("abort.E2.vld", 8'(so_valid), 8'h1);
        rst = 1'b0;
        #1;
        check_idle("abort.async");
        req = 2'b00;
        repeat (3) begin
            tick();
            check("abort.no_done", 8'(done), 8'h0);
        end
        rst = 1'b1;
        tick();
        check_idle("abort.release");
        check("abort.queue_empty", 8'(exp_q.size()), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
